instr_buffer: RTL and testbench

INSTR_BUFFER -- requirements
Module: instr_buffer

---
 rtl/instr_buffer.sv | 112 +++++++++++
 tb/tb_instr_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: circular FIFO of {pc, instr, fault}.
// Optional empty-buffer fetch-to-decode bypass is enabled by defining INSTR_BUFFER_BYPASS_EN.
module instr_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     in_fault,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [63:0]       r_pc_mem    [DEPTH];
  logic [31:0]       r_instr_mem [DEPTH];
  logic              r_fault_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_bypass;
  logic              w_stored_vld;
  logic              w_push;
  logic              w_pop;
  logic [31:0]       w_in_instr;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

`ifdef INSTR_BUFFER_BYPASS_EN
  // An instruction arriving at an empty buffer while decode is ready skips storage.
  assign w_bypass = rstn && w_empty && in_valid && out_ready && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // rstn is folded in so the handshake outputs stay low throughout reset.
  assign in_ready     = rstn && !w_full && !flush;
  assign w_stored_vld = rstn && !w_empty && !flush;
  assign out_valid    = w_stored_vld || w_bypass;

  assign w_push = in_valid && in_ready && !w_bypass;
  assign w_pop  = w_stored_vld && out_ready;

  // A faulting fetch carries no usable instruction word.
  assign w_in_instr = in_fault ? 32'h0 : in_instr;

  always_comb begin
    out_pc    = 64'h0;
    out_instr = 32'h0;
    out_fault = 1'b0;
    if (w_bypass) begin
      out_pc    = in_pc;
      out_instr = w_in_instr;
      out_fault = in_fault;
    end else if (w_stored_vld) begin
      out_pc    = r_pc_mem[r_head];
      out_instr = r_instr_mem[r_head];
      out_fault = r_fault_mem[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]    <= in_pc;
      r_instr_mem[r_tail] <= w_in_instr;
      r_fault_mem[r_tail] <= in_fault;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_instr_buffer.sv
// Directed self-checking bench for instr_buffer (DEPTH=4), with or without INSTR_BUFFER_BYPASS_EN.
module tb_instr_buffer;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_fault;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  instr_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_fault  (in_fault),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_fault (out_fault),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; checks happen 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 64'h0;
    in_instr  = 32'h0;
    in_fault  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    in_valid = 1'b1;
    in_pc    = 64'hABC0;
    in_instr = 32'h00000013;
    repeat (2) tick();
    #1;
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0)
      begin errors++; $display("FAIL reset_out got vld=%b pc=%h instr=%h exp 0/0/0", out_valid, out_pc, out_instr); end
    in_valid = 1'b0;
    rstn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_fill();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h1000 + 64'(4 * i);
      in_instr = 32'h00000013;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%b exp=1", i, in_ready); end
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_latency got=%b exp=0", out_valid); end
      end
      tick();
    end
    in_pc = 64'h1010;
    #1;
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_pc !== 64'h1000 || out_valid !== 1'b1)
      begin errors++; $display("FAIL fill_head got pc=%h vld=%b exp pc=1000 vld=1", out_pc, out_valid); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd4 || out_pc !== 64'h1000 || out_instr !== 32'h00000013)
      begin errors++; $display("FAIL fill_hold got cnt=%0d pc=%h instr=%h exp 4/1000/00000013", count, out_pc, out_instr); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4 * i))
        begin errors++; $display("FAIL drain_%0d got vld=%b pc=%h exp vld=1 pc=%h", i, out_valid, out_pc, 64'h1000 + 64'(4 * i)); end
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_full_pop_ready got=%b exp=0", in_ready); end
      end
      tick();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || count !== 3'd0)
      begin errors++; $display("FAIL drain_empty got vld=%b instr=%h cnt=%0d exp 0/0/0", out_valid, out_instr, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    idle_inputs();
    in_valid = 1'b1;
    in_pc    = 64'h2000;
    in_instr = 32'h00000100;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      in_pc    = 64'h2000 + 64'(4 * i);
      in_instr = 32'h00000100 + 32'(i);
      #1;
      checks++;
      if (out_pc !== 64'h2000 + 64'(4 * (i - 1)) || out_instr !== 32'h00000100 + 32'(i - 1) || count !== 3'd1)
        begin errors++; $display("FAIL wrap_%0d got pc=%h instr=%h cnt=%0d exp pc=%h instr=%h cnt=1", i, out_pc, out_instr, count,
                                 64'h2000 + 64'(4 * (i - 1)), 32'h00000100 + 32'(i - 1)); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_pc !== 64'h2014 || out_instr !== 32'h00000105)
      begin errors++; $display("FAIL wrap_last got pc=%h instr=%h exp pc=2014 instr=00000105", out_pc, out_instr); end
    tick();
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL wrap_empty got cnt=%0d vld=%b exp 0/0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h3000 + 64'(4 * i);
      in_instr = 32'h00000013;
      tick();
    end
    flush     = 1'b1;
    in_pc     = 64'h3FF0;
    in_instr  = 32'h12345678;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_pc !== 64'h0)
      begin errors++; $display("FAIL flush_cycle got vld=%b rdy=%b pc=%h exp 0/0/0", out_valid, in_ready, out_pc); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_after got cnt=%0d vld=%b exp 0/0", count, out_valid); end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0)
      begin errors++; $display("FAIL flush_dropped got vld=%b instr=%h exp 0/0", out_valid, out_instr); end
    out_ready = 1'b0;
  endtask

  task automatic test_fault();
    idle_inputs();
    in_valid = 1'b1;
    in_pc    = 64'h4000;
    in_instr = 32'hDEADBEEF;
    in_fault = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_instr !== 32'h0 || out_pc !== 64'h4000)
      begin errors++; $display("FAIL fault_entry got vld=%b flt=%b instr=%h pc=%h exp 1/1/0/4000", out_valid, out_fault, out_instr, out_pc); end
    out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_fault !== 1'b0)
      begin errors++; $display("FAIL fault_popped got vld=%b flt=%b exp 0/0", out_valid, out_fault); end
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    idle_inputs();
    in_valid  = 1'b1;
    in_pc     = 64'h5000;
    in_instr  = 32'h00100093;
    out_ready = 1'b1;
    #1;
`ifdef INSTR_BUFFER_BYPASS_EN
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00100093 || out_pc !== 64'h5000)
      begin errors++; $display("FAIL bypass_fwd got vld=%b instr=%h pc=%h exp 1/00100093/5000", out_valid, out_instr, out_pc); end
    checks++;
    if (in_ready !== 1'b1 || count !== 3'd0)
      begin errors++; $display("FAIL bypass_state got rdy=%b cnt=%0d exp 1/0", in_ready, count); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL bypass_not_stored got cnt=%0d vld=%b exp 0/0", count, out_valid); end
`else
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL nobypass_same_cycle got vld=%b exp 0", out_valid); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00100093 || count !== 3'd1)
      begin errors++; $display("FAIL nobypass_next got vld=%b instr=%h cnt=%0d exp 1/00100093/1", out_valid, out_instr, count); end
    tick();
    #1;
    checks++;
    if (count !== 3'd0)
      begin errors++; $display("FAIL nobypass_drained got cnt=%0d exp 0", count); end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h6000 + 64'(4 * i);
      in_instr = 32'h00000013;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL reset_mid got cnt=%0d vld=%b rdy=%b exp 0/0/0", count, out_valid, in_ready); end
    tick();
    rstn = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_mid_release got vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_fault();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
